// File: rtl/rx_pkg.sv
// Shared definitions for the receive frame parser and the payload checker it feeds:
// parser states, frame word positions, default tag values and pattern type codes.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TAG,
        ST_SEED,
        ST_PAYLOAD,
        ST_DROP
    } state_e;

    localparam logic [2:0] HDR_LAST = 3'd3;
    localparam logic [2:0] TAG_IDX  = 3'd4;
    localparam logic [2:0] SEED_IDX = 3'd5;

    localparam logic [15:0] ETH_TYPE_DEF = 16'h88B5;
    localparam logic [15:0] MAGIC_DEF    = 16'h5AA5;

    typedef enum logic [3:0] {
        PT_CONST  = 4'd0,
        PT_INCR   = 4'd1,
        PT_DECR   = 4'd2,
        PT_PRBS31 = 4'd4,
        PT_PRBS23 = 4'd5,
        PT_PRBS15 = 4'd6,
        PT_PRBS11 = 4'd7
    } pat_type_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_frame_parse.sv
// Strips the Ethernet header from the MAC stream, validates the tester tag and feeds
// the payload checker; one cycle latency, no backpressure (every valid word is consumed).
module rx_frame_parse
    import rx_pkg::*;
#(
    parameter logic [15:0] ETH_TYPE = ETH_TYPE_DEF,
    parameter logic [15:0] MAGIC    = MAGIC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [1:0]  rx_empty,
    input  logic        rx_err,
    input  logic [31:0] rx_data,
    output logic        payload_pre,
    output logic [31:0] payload_seed,
    output logic [3:0]  payload_type,
    output logic        payload_valid,
    output logic [31:0] payload_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_words
);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [15:0] cnt_q;
    logic [3:0]  type_lat_q;
    logic        pre_q;
    logic [31:0] seed_q;
    logic [3:0]  type_q;
    logic        vld_q;
    logic [31:0] data_q;
    logic        done_q;
    logic        ok_q;
    logic [15:0] words_q;

    logic        fwd;
    logic [15:0] words_d;

    // A partial eop word carries only trailing padding and is neither forwarded nor counted.
    assign fwd     = rx_valid && !rx_sop && (state_q == ST_PAYLOAD)
                     && !(rx_eop && (rx_empty != 2'd0));
    assign words_d = fwd ? sat_inc16(cnt_q) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            type_lat_q <= '0;
            pre_q      <= 1'b0;
            seed_q     <= '0;
            type_q     <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            words_q    <= '0;
        end else begin
            pre_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            if (rx_valid && rx_sop) begin
                // sop mid-frame closes the old frame as failed; sop+eop is a runt
                if (state_q != ST_IDLE || rx_eop) begin
                    done_q  <= 1'b1;
                    ok_q    <= 1'b0;
                    words_q <= rx_eop ? 16'd0 : cnt_q;
                end
                cnt_q   <= '0;
                idx_q   <= 3'd1;
                state_q <= rx_eop ? ST_IDLE : ST_HDR;
            end else if (rx_valid) begin
                case (state_q)
                    ST_HDR: begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == HDR_LAST)
                            state_q <= (rx_data[15:0] == ETH_TYPE) ? ST_TAG : ST_DROP;
                    end
                    ST_TAG: begin
                        if (rx_data[31:16] == MAGIC) begin
                            type_lat_q <= rx_data[3:0];
                            state_q    <= ST_SEED;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                    ST_SEED: begin
                        seed_q  <= rx_data;
                        type_q  <= type_lat_q;
                        pre_q   <= 1'b1;
                        state_q <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        if (fwd) begin
                            vld_q  <= 1'b1;
                            data_q <= rx_data;
                            cnt_q  <= words_d;
                        end
                    end
                    default: ;
                endcase
                if (rx_eop && state_q != ST_IDLE) begin
                    done_q  <= 1'b1;
                    ok_q    <= (state_q == ST_PAYLOAD) && !rx_err && (words_d != 16'd0);
                    words_q <= words_d;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign payload_pre   = pre_q;
    assign payload_seed  = seed_q;
    assign payload_type  = type_q;
    assign payload_valid = vld_q;
    assign payload_data  = data_q;
    assign frame_done    = done_q;
    assign frame_ok      = ok_q;
    assign frame_words   = words_q;

endmodule

// File: tb/tb_rx_frame_parse.sv
// Random and directed frames for rx_frame_parse, scored against a whole-frame model.
module tb_rx_frame_parse;
    import rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic [1:0]  rx_empty = '0;
    logic        rx_err = 1'b0;
    logic [31:0] rx_data = '0;
    logic        payload_pre;
    logic [31:0] payload_seed;
    logic [3:0]  payload_type;
    logic        payload_valid;
    logic [31:0] payload_data;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_words;

    always #5 clk = ~clk;

    rx_frame_parse dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_empty(rx_empty), .rx_err(rx_err), .rx_data(rx_data),
        .payload_pre(payload_pre), .payload_seed(payload_seed), .payload_type(payload_type),
        .payload_valid(payload_valid), .payload_data(payload_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_words(frame_words)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] fw[$];
    logic [35:0] exp_pre[$];
    logic [31:0] exp_pay[$];
    logic [16:0] exp_done[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_pre"},   64'(payload_pre),   64'd0);
        check_eq({tag, "_seed"},  64'(payload_seed),  64'd0);
        check_eq({tag, "_type"},  64'(payload_type),  64'd0);
        check_eq({tag, "_vld"},   64'(payload_valid), 64'd0);
        check_eq({tag, "_data"},  64'(payload_data),  64'd0);
        check_eq({tag, "_done"},  64'(frame_done),    64'd0);
        check_eq({tag, "_ok"},    64'(frame_ok),      64'd0);
        check_eq({tag, "_words"}, 64'(frame_words),   64'd0);
    endtask

    task automatic monitor_loop();
        logic [35:0] ep;
        logic [16:0] ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (payload_pre) begin
                    check_eq("pre_vld_overlap", 64'(payload_valid), 64'd0);
                    if (exp_pre.size() == 0) check_eq("pre_unexpected", 64'd1, 64'd0);
                    else begin
                        ep = exp_pre.pop_front();
                        check_eq("pre_seed", 64'(payload_seed), 64'(ep[31:0]));
                        check_eq("pre_type", 64'(payload_type), 64'(ep[35:32]));
                    end
                end
                if (payload_valid) begin
                    if (exp_pay.size() == 0) check_eq("pay_unexpected", 64'd1, 64'd0);
                    else check_eq("pay_data", 64'(payload_data), 64'(exp_pay.pop_front()));
                end
                if (frame_done) begin
                    if (exp_done.size() == 0) check_eq("done_unexpected", 64'd1, 64'd0);
                    else begin
                        ed = exp_done.pop_front();
                        check_eq("done_ok", 64'(frame_ok), 64'(ed[16]));
                        check_eq("done_words", 64'(frame_words), 64'(ed[15:0]));
                    end
                end
            end
        end
    endtask

    task automatic build_frame(input bit good_eth, input bit good_mag, input logic [3:0] typ,
                               input logic [31:0] seed, input int n);
        fw.delete();
        fw.push_back({16'h0000, 16'($urandom)});
        fw.push_back($urandom);
        fw.push_back($urandom);
        fw.push_back({16'($urandom), good_eth ? ETH_TYPE_DEF : 16'h0800});
        fw.push_back({good_mag ? MAGIC_DEF : 16'hA55A, 12'($urandom), typ});
        fw.push_back(seed);
        while (fw.size() < n) fw.push_back($urandom);
        while (fw.size() > n) void'(fw.pop_back());
    endtask

    // mode 0: ends with eop, 1: cut short by the next sop, 2: cut short by reset
    task automatic model_frame(input int mode, input logic [1:0] empty, input bit err);
        int  n = fw.size();
        int  cnt = 0;
        bit  hdr_ok, tag_ok, reached;
        if (mode == 0 && n == 1) begin
            exp_done.push_back({1'b0, 16'd0});
            return;
        end
        hdr_ok  = (n > int'(HDR_LAST)) && (fw[HDR_LAST][15:0] == ETH_TYPE_DEF);
        tag_ok  = hdr_ok && (n > int'(TAG_IDX)) && (fw[TAG_IDX][31:16] == MAGIC_DEF);
        if (tag_ok && n > int'(SEED_IDX)) exp_pre.push_back({fw[TAG_IDX][3:0], fw[SEED_IDX]});
        reached = tag_ok && (n > int'(SEED_IDX) + 1);
        if (reached)
            for (int i = int'(SEED_IDX) + 1; i < n; i++)
                if (!(mode == 0 && i == n - 1 && empty != 2'd0)) begin
                    exp_pay.push_back(fw[i]);
                    cnt++;
                end
        if (mode == 0) exp_done.push_back({reached && cnt >= 1 && !err, 16'(cnt)});
        else if (mode == 1) exp_done.push_back({1'b0, 16'(cnt)});
    endtask

    task automatic drive_word(input bit v, input bit sop, input bit eop, input logic [1:0] emp,
                              input bit err, input logic [31:0] d);
        rx_valid = v; rx_sop = sop; rx_eop = eop; rx_empty = emp; rx_err = err; rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive_word(1'b0, 1'($urandom), 1'($urandom), 2'($urandom),
                                               1'($urandom), $urandom);
    endtask

    task automatic send_frame(input int mode, input logic [1:0] empty, input bit err, input int gap_pct);
        bit last_eop;
        model_frame(mode, empty, err);
        for (int i = 0; i < fw.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) idle(1);
            last_eop = (mode == 0) && (i == fw.size() - 1);
            drive_word(1'b1, i == 0, last_eop, last_eop ? empty : 2'($urandom),
                       last_eop ? err : 1'($urandom), fw[i]);
        end
    endtask

    initial begin
        int  mode, n, prev_mode;
        bit  err;
        logic [1:0] emp;
        fork
            monitor_loop();
        join_none

        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        build_frame(1, 1, 4'd1, 32'h0000_0100, 6 + 8);
        send_frame(0, 2'd0, 1'b0, 0);
        build_frame(0, 1, 4'd1, 32'h1234_5678, 6 + 4);
        send_frame(0, 2'd0, 1'b0, 0);
        build_frame(1, 1, 4'd2, 32'hCAFE_0001, 6 + 6);
        send_frame(0, 2'd2, 1'b0, 0);
        build_frame(1, 1, 4'd4, 32'h0BAD_F00D, 6 + 3);
        send_frame(0, 2'd0, 1'b1, 0);
        build_frame(1, 1, 4'd5, 32'h0000_00AA, 6 + 2);
        send_frame(1, 2'd0, 1'b0, 0);
        build_frame(1, 1, 4'd6, 32'h0000_00BB, 6 + 4);
        send_frame(0, 2'd0, 1'b0, 0);
        idle(3);

        build_frame(1, 1, 4'd7, 32'h7777_0000, 6 + 2);
        send_frame(2, 2'd0, 1'b0, 0);
        rx_valid = 1'b0;
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_word(1'b1, 1'b0, i == 3, 2'd0, 1'b0, $urandom);
        build_frame(1, 1, 4'd0, 32'h5555_AAAA, 6 + 5);
        send_frame(0, 2'd0, 1'b0, 0);

        prev_mode = 0;
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(9) == 0) n = int'($urandom_range(5, (prev_mode == 1) ? 2 : 1));
            else n = 6 + int'($urandom_range(12, 1));
            mode = ($urandom_range(9) == 0) ? 1 : 0;
            emp  = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom);
            err  = ($urandom_range(99) < 15);
            build_frame($urandom_range(99) < 85, $urandom_range(99) < 85, 4'($urandom),
                        $urandom, n);
            send_frame(mode, emp, err, 20);
            if (mode == 0) begin
                for (int j = int'($urandom_range(2)); j > 0; j--)
                    drive_word(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom);
                idle(int'($urandom_range(2)));
            end
            prev_mode = mode;
        end
        build_frame(1, 1, 4'd1, 32'h0000_0001, 6 + 1);
        send_frame(0, 2'd0, 1'b0, 0);
        idle(5);

        check_eq("left_pre",  64'(exp_pre.size()),  64'd0);
        check_eq("left_pay",  64'(exp_pay.size()),  64'd0);
        check_eq("left_done", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_frame_parse.md
# rx_frame_parse

Receive-side frame parser that turns the 32-bit MAC receive stream into the tester payload-check interface. It strips the Ethernet header, validates the tester tag, extracts the pattern type and seed, and emits the `payload_pre`/`payload_valid` sequence consumed by the downstream payload checker. It also reports per-frame status: done, ok, and payload word count.

## Interface
Parameters:
- `ETH_TYPE`, 16'h88B5: required EtherType of tester frames.
- `MAGIC`, 16'h5AA5: required tag magic in word 4 [31:16].

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  MAC word strobe; no backpressure, every valid word is accepted.
- `rx_sop`  in  1  first word of frame.
- `rx_eop`  in  1  last word of frame.
- `rx_empty`  in  2  unused bytes in eop word (0 = full word).
- `rx_err`  in  1  MAC error flag, meaningful with `rx_eop`.
- `rx_data`  in  32  frame word, big-endian byte order; MAC runs with 2-byte shift (word 0 = 2 pad bytes + dst[47:32]).
- `payload_pre`  out  1  one-cycle pulse: load seed/type, clear error sum.
- `payload_seed`  out  32  pattern seed, held until next `payload_pre`.
- `payload_type`  out  4  pattern type, held until next `payload_pre`.
- `payload_valid`  out  1  one payload word present.
- `payload_data`  out  32  payload word.
- `frame_done`  out  1  one-cycle end-of-frame pulse.
- `frame_ok`  out  1  frame status, valid with `frame_done`.
- `frame_words`  out  16  payload words forwarded in the frame, valid with `frame_done`.

## Operation
- Frame layout: words 0–3 hold pad, dst, and src; word 3 [15:0] is the EtherType. Word 4 is {magic[15:0], rsvd[11:0], type[3:0]}. Word 5 is the seed. Words 6 through eop are payload.
- States:
  - IDLE: wait for `rx_valid & rx_sop`, then go to HDR with word count 1.
  - HDR: count words 1–3. At word 3, an EtherType mismatch goes to DROP; otherwise go to TAG.
  - TAG: a magic mismatch goes to DROP. Otherwise latch type[3:0] internally and go to SEED.
  - SEED: latch the seed, pulse `payload_pre`, and go to PAYLOAD.
  - PAYLOAD: forward each word as `payload_valid`/`payload_data`.
  - DROP: swallow words until eop, then return to IDLE.
- `rx_eop` in any state returns the parser to IDLE and pulses `frame_done`.
- `frame_ok` = 1 only if all of the following hold:
  - PAYLOAD was reached;
  - `frame_words` ≥ 1;
  - `rx_err` = 0 on the eop word.
- An eop word with `rx_empty` ≠ 0 in PAYLOAD is not forwarded and is not counted. The frame is still ok if the other conditions hold.
- `rx_sop` in any state other than IDLE aborts the current frame: `frame_done` pulses with `frame_ok` = 0. The sop word is then parsed as word 0 of a new frame.
- `rx_sop & rx_eop` together: pulse `frame_done` with `frame_ok` = 0, then return to IDLE.
- Words without `rx_valid` are ignored and the state holds.
- In IDLE, words with `rx_sop` = 0 are ignored.
- `frame_words` counter: cleared on sop, incremented per forwarded word, saturates at 16'hFFFF.
- `payload_pre` is never asserted for dropped or truncated frames (eop before the seed word).

## Timing
- All outputs are registered.
- Every output resets to 0, including `payload_seed` and `payload_type`.
- Reset mid-frame: the parser returns to IDLE and emits no `frame_done` for the aborted frame.
- `payload_pre` is asserted in cycle N+1 for a seed word accepted in cycle N. `payload_seed`/`payload_type` are valid in that same cycle.
- Payload word accepted in cycle N: `payload_valid` in cycle N+1, with latency 1.
- `payload_pre` and `payload_valid` are never high in the same cycle. The first payload word is at least one cycle after `payload_pre`.
- Eop accepted in cycle N: `frame_done`, `frame_ok`, and `frame_words` are driven in cycle N+1. This coincides with the last `payload_valid` if that word is forwarded.
- Back-to-back frames: a sop in the cycle after eop is accepted without a bubble.
- `payload_data` holds its last value when `payload_valid` = 0.

## Structure
- Shared package `rx_pkg`:
  - state enum;
  - word-index constants (HDR_LAST = 3, TAG_IDX = 4, SEED_IDX = 5);
  - defaults for `ETH_TYPE` and `MAGIC`;
  - the type codes shared with the payload checker (0 const, 1 incr, 2 decr, 4–7 PRBS31/23/15/11).
- Single module, no sub-module. State register, word index counter, and frame word counter all live in this block.

## Test plan
- Good frame: type 1, seed 32'h0000_0100, 8 full payload words → one `payload_pre` with seed 32'h100 and type 1, then 8 `payload_valid` words; `frame_done` with ok = 1, words = 8.
- EtherType 16'h0800 → no `payload_pre`, no `payload_valid`; `frame_done` with ok = 0, words = 0.
- Eop on a payload word with `rx_empty` = 2 after 5 full words → 5 words forwarded; ok = 1, words = 5.
- Eop with `rx_err` = 1 after 3 payload words → 3 words forwarded; ok = 0, words = 3.
- Sop arrives at payload word 2, followed by a full good frame (4 words) → `frame_done` ok = 0 / words = 2, then `payload_pre` and 4 words, then `frame_done` ok = 1 / words = 4.
- `rst_n` low for 1 cycle in the middle of PAYLOAD → outputs 0 and no `frame_done`; words up to the next sop are ignored, and the next frame parses normally.
